// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op/state types and op-class helpers shared by muldiv_iter and its interface.
package muldiv_pkg;

    typedef enum logic [2:0] {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU} mdop_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic is_div(input mdop_t op);
        return op inside {DIV, DIVU, REM, REMU};
    endfunction

    function automatic logic is_signed_a(input mdop_t op);
        return op inside {MUL, MULH, MULHSU, DIV, REM};
    endfunction

    function automatic logic is_signed_b(input mdop_t op);
        return op inside {MUL, MULH, DIV, REM};
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the execute stage (master) and muldiv_iter (slave).
interface muldiv_if #(
    parameter int XLEN = 32
);
    import muldiv_pkg::*;

    logic            go;
    logic            kill;
    mdop_t           op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output go, kill, op, a, b, input busy, done, result);
    modport slave (input go, kill, op, a, b, output busy, done, result);

endinterface

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: DIV_STEP restoring-division bits per call, dividend bits shifted in MSB first.
module muldiv_div_step #(
    parameter int XLEN     = 32,
    parameter int DIV_STEP = 1
) (
    input  logic [XLEN-1:0]     i_rem,
    input  logic [DIV_STEP-1:0] i_din,
    input  logic [XLEN-1:0]     i_dvs,
    output logic [XLEN-1:0]     o_rem,
    output logic [DIV_STEP-1:0] o_q
);
    logic [XLEN:0] w_try;
    logic [XLEN:0] w_diff;

    // Partial remainder stays below the divisor, so the shifted trial value fits in XLEN+1 bits.
    always_comb begin
        o_rem  = i_rem;
        o_q    = '0;
        w_try  = '0;
        w_diff = '0;
        for (int k = DIV_STEP - 1; k >= 0; k--) begin
            w_try  = {o_rem, i_din[k]};
            w_diff = w_try - {1'b0, i_dvs};
            o_q[k] = ~w_diff[XLEN];
            o_rem  = w_diff[XLEN] ? w_try[XLEN-1:0] : w_diff[XLEN-1:0];
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M multiply (radix-2^MUL_STEP shift-add) and restoring divide on magnitudes.
// Optional MULDIV_EARLY_OUT_EN: multiply stops once the multiplier is exhausted; divide skips dividend leading zeros.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 4,
    parameter int DIV_STEP = 1
) (
    input logic     clk_core,
    input logic     reset_n,
    muldiv_if.slave md
);
    localparam int              W2      = 2 * XLEN;
    localparam int              CW      = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   MUL_CNT = CW'(XLEN / MUL_STEP);
    localparam logic [CW-1:0]   DIV_CNT = CW'(XLEN / DIV_STEP);
    localparam logic [XLEN-1:0] SMIN    = {1'b1, {(XLEN - 1){1'b0}}};

    state_t              r_state, w_next;
    mdop_t               r_op;
    logic [CW-1:0]       r_cnt, w_div_cnt;
    logic                r_neg_q, r_neg_r;
    logic [W2-1:0]       r_acc, r_mcand, w_acc_nx, w_prod;
    logic [XLEN-1:0]     r_mplier, r_rem, r_dvd, r_dvs, r_result;
    logic [XLEN-1:0]     w_mag_a, w_mag_b, w_dvd0, w_spec_res, w_rem_nx, w_quo, w_run_res;
    logic [DIV_STEP-1:0] w_q;
    logic                w_sa, w_sb, w_special, w_start, w_last;

    assign w_sa      = is_signed_a(md.op) & md.a[XLEN-1];
    assign w_sb      = is_signed_b(md.op) & md.b[XLEN-1];
    assign w_mag_a   = w_sa ? -md.a : md.a;
    assign w_mag_b   = w_sb ? -md.b : md.b;
    assign w_start   = r_state == IDLE && md.go && !md.kill;

    // Divide by zero and signed overflow have fixed answers and never enter RUN.
    assign w_special  = is_div(md.op) && (md.b == '0 || (is_signed_b(md.op) && md.a == SMIN && md.b == '1));
    assign w_spec_res = md.op inside {REM, REMU} ? (md.b == '0 ? md.a : '0) : (md.b == '0 ? '1 : md.a);

    assign w_acc_nx = r_acc + r_mcand * W2'(r_mplier[MUL_STEP-1:0]);
    assign w_prod   = r_neg_q ? -w_acc_nx : w_acc_nx;

    muldiv_div_step #(
        .XLEN    (XLEN),
        .DIV_STEP(DIV_STEP)
    ) u_div_step (
        .i_rem(r_rem),
        .i_din(r_dvd[XLEN-1 -: DIV_STEP]),
        .i_dvs(r_dvs),
        .o_rem(w_rem_nx),
        .o_q  (w_q)
    );

    // Quotient bits fill r_dvd from the bottom as the dividend shifts out the top.
    assign w_quo     = {r_dvd[XLEN-DIV_STEP-1:0], w_q};
    assign w_run_res = is_div(r_op)
                     ? (r_op inside {REM, REMU} ? (r_neg_r ? -w_rem_nx : w_rem_nx) : (r_neg_q ? -w_quo : w_quo))
                     : (r_op == MUL ? w_prod[XLEN-1:0] : w_prod[W2-1:XLEN]);

`ifdef MULDIV_EARLY_OUT_EN
    function automatic int lead_zeros(input logic [XLEN-1:0] v);
        int n = XLEN;
        for (int i = 0; i < XLEN; i++) if (v[i]) n = XLEN - 1 - i;
        n = (n / DIV_STEP) * DIV_STEP;
        return n > XLEN - DIV_STEP ? XLEN - DIV_STEP : n;
    endfunction

    int w_lz;

    assign w_lz      = lead_zeros(w_mag_a);
    assign w_dvd0    = w_mag_a << w_lz;
    assign w_div_cnt = CW'((XLEN - w_lz) / DIV_STEP);
    assign w_last    = r_cnt == CW'(1) || (!is_div(r_op) && (r_mplier >> MUL_STEP) == '0);
`else
    assign w_dvd0    = w_mag_a;
    assign w_div_cnt = DIV_CNT;
    assign w_last    = r_cnt == CW'(1);
`endif

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (md.kill) w_next = IDLE;
        else if (r_state == IDLE) w_next = md.go ? (w_special ? DONE : RUN) : IDLE;
        else if (r_state == RUN) w_next = w_last ? DONE : RUN;
        else w_next = md.go ? DONE : IDLE;
    end

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            r_op     <= MUL;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_result <= '0;
        end else if (w_start) begin
            r_op     <= md.op;
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_cnt    <= is_div(md.op) ? w_div_cnt : MUL_CNT;
            r_acc    <= '0;
            r_mcand  <= W2'(w_mag_a);
            r_mplier <= w_mag_b;
            r_rem    <= '0;
            r_dvd    <= w_dvd0;
            r_dvs    <= w_mag_b;
            if (w_special) r_result <= w_spec_res;
        end else if (r_state == RUN && !md.kill) begin
            r_cnt <= r_cnt - CW'(1);
            if (is_div(r_op)) begin
                r_rem <= w_rem_nx;
                r_dvd <= w_quo;
            end else begin
                r_acc    <= w_acc_nx;
                r_mcand  <= r_mcand << MUL_STEP;
                r_mplier <= r_mplier >> MUL_STEP;
            end
            if (w_last) r_result <= w_run_res;
        end
    end

    assign md.busy   = r_state != IDLE;
    assign md.done   = r_state == DONE;
    assign md.result = r_result;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed and random ops on muldiv_iter, checked against a plain-arithmetic RV32M model.
module tb_muldiv_iter;
    import muldiv_pkg::*;

    localparam int XLEN     = 32;
    localparam int MUL_STEP = 4;
    localparam int DIV_STEP = 1;
    localparam int MUL_LAT  = XLEN / MUL_STEP + 1;
    localparam int DIV_LAT  = XLEN / DIV_STEP + 1;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    int              n_checks = 0;
    int              n_fails  = 0;
    logic [XLEN-1:0] last_res = '0;
    logic [XLEN-1:0] edge_vals [4] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000};

    muldiv_if #(.XLEN(XLEN)) md ();

    muldiv_iter #(
        .XLEN    (XLEN),
        .MUL_STEP(MUL_STEP),
        .DIV_STEP(DIV_STEP)
    ) dut (
        .clk_core(clk),
        .reset_n (rst_n),
        .md      (md.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RISC-V M semantics straight from 64-bit signed/unsigned arithmetic.
    function automatic logic [31:0] ref_md(input mdop_t op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        p  = '0;
        case (op)
            MUL, MULH: p = sa * sb;
            MULHSU:    p = sa * ub;
            MULHU:     p = ua * ub;
            DIV:       if (b == 0) p = '1; else p = sa / sb;
            DIVU:      if (b == 0) p = '1; else p = ua / ub;
            REM:       if (b == 0) p = ua; else p = sa % sb;
            default:   if (b == 0) p = ua; else p = ua % ub;
        endcase
        return (op inside {MULH, MULHSU, MULHU}) ? p[63:32] : p[31:0];
    endfunction

    // Runs one op with go held; leaves go high with done observed.
    task automatic run_op(input mdop_t op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        int          lat;
        int          lim;
        exp = ref_md(op, a, b);
        if (!(op inside {DIV, DIVU, REM, REMU})) lim = MUL_LAT;
        else if (b == 0 || (op inside {DIV, REM} && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) lim = 1;
        else lim = DIV_LAT;
        md.go = 1'b1;
        md.op = op;
        md.a  = a;
        md.b  = b;
        lat   = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                md.a  = $urandom;
                md.b  = $urandom;
                md.op = mdop_t'($urandom_range(0, 7));
            end
        end while (!md.done && lat < 100);
`ifdef MULDIV_EARLY_OUT_EN
        check({"lat_max_", op.name()}, 64'(lat <= lim), 64'd1);
`else
        check({"lat_", op.name()}, 64'(lat), 64'(lim));
`endif
        check({"res_", op.name()}, 64'(md.result), 64'(exp));
        check({"busy_", op.name()}, 64'(md.busy), 64'd1);
        last_res = exp;
    endtask

    task automatic drop_go();
        md.go = 1'b0;
        @(posedge clk);
        #1;
        check("idle_busy", 64'(md.busy), 64'd0);
        check("idle_done", 64'(md.done), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb;
        mdop_t       rop;
        logic        seen_done;
        md.go   = 1'b0;
        md.kill = 1'b0;
        md.op   = MUL;
        md.a    = '0;
        md.b    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(md.busy), 64'd0);
        check("rst_done", 64'(md.done), 64'd0);
        check("rst_result", 64'(md.result), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(MUL, 32'hFFFF_FFFF, 32'd7);
        drop_go();
        run_op(MULHU, 32'hFFFF_FFFF, 32'd7);
        drop_go();
        run_op(MULH, 32'hFFFF_FFFF, 32'd7);
        drop_go();
        run_op(DIV, 32'hFFFF_FFEC, 32'd3);
        drop_go();
        run_op(REM, 32'hFFFF_FFEC, 32'd3);
        drop_go();
        run_op(DIVU, 32'd100, 32'd7);
        drop_go();
        run_op(REMU, 32'd100, 32'd7);
        drop_go();
        run_op(DIVU, 32'd5, 32'd0);
        drop_go();
        run_op(REM, 32'd5, 32'd0);
        drop_go();
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        drop_go();
        run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF);
        drop_go();
        // Kill mid-divide, then restart immediately while go is still high.
        run_op(MUL, 32'd11, 32'd13);
        drop_go();
        md.go     = 1'b1;
        md.op     = DIV;
        md.a      = 32'd1000;
        md.b      = 32'd7;
        seen_done = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            seen_done |= md.done;
        end
        md.kill = 1'b1;
        @(posedge clk);
        #1;
        check("kill_busy", 64'(md.busy), 64'd0);
        check("kill_done", 64'(md.done), 64'd0);
        check("kill_result", 64'(md.result), 64'(last_res));
        @(posedge clk);
        #1;
        check("kill_go_nostart", 64'(md.busy), 64'd0);
        check("kill_never_done", 64'(seen_done), 64'd0);
        md.kill = 1'b0;
        run_op(MUL, 32'd6, 32'd7);
        drop_go();
        // Hold go after done: result stays, no restart.
        run_op(MUL, 32'hFFFF_FFFF, 32'd7);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("hold_done", 64'(md.done), 64'd1);
            check("hold_result", 64'(md.result), 64'hFFFF_FFF9);
        end
        drop_go();
        run_op(MULHSU, 32'hFFFF_FFFE, 32'd3);
        drop_go();
        // Asynchronous reset in the middle of RUN.
        md.go = 1'b1;
        md.op = MUL;
        md.a  = 32'd3;
        md.b  = 32'd5;
        repeat (3) @(posedge clk);
        #3;
        check("pre_rst_busy", 64'(md.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(md.busy), 64'd0);
        check("arst_done", 64'(md.done), 64'd0);
        check("arst_result", 64'(md.result), 64'd0);
        md.go = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(MUL, 32'h0001_0000, 32'h0001_0000);
        drop_go();
        run_op(MULHU, 32'h0001_0000, 32'h0001_0000);
        drop_go();
        for (int i = 0; i < 40; i++) begin
            rop = mdop_t'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            run_op(rop, ra, rb);
            drop_go();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
